// File: rtl/inst_encoder_if.sv
// Tuple input handshake and instruction-memory write port of the instruction encoder.
// master = program source / memory model side, slave = encoder side.
interface inst_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_opcode;
    logic [2:0]        in_da;
    logic [2:0]        in_aa;
    logic [2:0]        in_ba;
    logic              in_last;
    logic              im_we;
    logic              im_ready;
    logic [ADDR_W-1:0] im_addr;
    logic [16:0]       im_wdata;

    modport master (
        output in_valid, in_opcode, in_da, in_aa, in_ba, in_last, im_ready,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_opcode, in_da, in_aa, in_ba, in_last, im_ready,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/inst_encoder.sv
// Packs (opcode, DA, AA, BA) tuples into 17-bit words, buffers them and writes them into
// instruction memory. Define INST_ENCODER_CKSUM_EN to build the running XOR checksum.
//   state  | meaning
//   S_IDLE | out of reset, waiting for start
//   S_LOAD | accepting tuples and writing words
//   S_DONE | last word written
//   S_ERR  | address space exhausted before the last word
module inst_encoder #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    inst_encoder_if.slave   bus,
    output logic            done,
    output logic            ovf,
    output logic [ADDR_W:0] words,
    output logic [16:0]     cksum
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_TOP  = {ADDR_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [17:0]       fifo_q [FIFO_DEPTH];
    logic [17:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic        full, empty, loading;
    logic        in_ready_c, im_we_c, push, wr;
    logic [17:0] head;
    logic [16:0] packed_word;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full        = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign loading     = (state_q == S_LOAD);
    assign in_ready_c  = loading && !full && !start;
    assign im_we_c     = loading && !empty && !start;
    assign push        = bus.in_valid && in_ready_c;
    assign wr          = im_we_c && bus.im_ready;
    assign head        = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign packed_word = {bus.in_opcode, bus.in_da, bus.in_aa, bus.in_ba};

    assign bus.in_ready = in_ready_c;
    assign bus.im_we    = im_we_c;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = im_we_c ? head[16:0] : 17'd0;
    assign done         = done_q;
    assign ovf          = ovf_q;
    assign words        = words_q;

    always_comb begin
        state_d  = state_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        words_d  = words_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        if (start) begin
            state_d  = S_LOAD;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            addr_d   = ADDR_BASE;
            words_d  = '0;
            ovf_d    = 1'b0;
        end else if (loading) begin
            if (push) begin
                fifo_d[wr_ptr_q[PTR_W-1:0]] = {bus.in_last, packed_word};
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end
            if (wr) begin
                rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
                words_d  = words_q + (ADDR_W+1)'(1);
                if (addr_q != ADDR_TOP) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (head[17]) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (addr_q == ADDR_TOP) begin
                    // Out of address space: drop whatever is still buffered.
                    state_d  = S_ERR;
                    ovf_d    = 1'b1;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            addr_q   <= ADDR_BASE;
            words_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            addr_q   <= addr_d;
            words_q  <= words_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

`ifdef INST_ENCODER_CKSUM_EN
    logic [16:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (start) begin
            cksum_d = '0;
        end else if (wr) begin
            cksum_d = cksum_q ^ head[16:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = 17'd0;
`endif
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: an 8-bit-address instance for the load flows and a
// 3-bit-address instance for address-space exhaustion.
module tb_inst_encoder;
`ifdef INST_ENCODER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic start_a, start_b;
    logic done_a, done_b, ovf_a, ovf_b;
    logic [8:0]  words_a;
    logic [3:0]  words_b;
    logic [16:0] cksum_a, cksum_b;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt_a = 0;
    int log_addr_a[$];
    logic [16:0] log_data_a[$];
    int log_addr_b[$];
    logic [16:0] log_data_b[$];

    inst_encoder_if #(.ADDR_W(8)) bus_a ();
    inst_encoder_if #(.ADDR_W(3)) bus_b ();

    inst_encoder #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(bus_a),
        .done(done_a), .ovf(ovf_a), .words(words_a), .cksum(cksum_a)
    );

    inst_encoder #(.ADDR_W(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(bus_b),
        .done(done_b), .ovf(ovf_b), .words(words_b), .cksum(cksum_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/done monitors sample mid-way between the driving negedge and the next posedge.
    always @(negedge clk) begin
        #2;
        if (bus_a.im_we && bus_a.im_ready) begin
            log_addr_a.push_back(int'(bus_a.im_addr));
            log_data_a.push_back(bus_a.im_wdata);
        end
        if (bus_b.im_we && bus_b.im_ready) begin
            log_addr_b.push_back(int'(bus_b.im_addr));
            log_data_b.push_back(bus_b.im_wdata);
        end
        if (done_a) done_cnt_a++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] exp_word(input int i);
        int v;
        v = ((16 + i) << 9) | ((i & 7) << 6) | (((7 - i) & 7) << 3) | ((i + 1) & 7);
        return v[16:0];
    endfunction

    task automatic step();
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Presents a tuple each negedge until accepted or the bound runs out; on give-up valid drops.
    task automatic push(input bit sel, input logic [7:0] op, input logic [2:0] da,
                        input logic [2:0] aa, input logic [2:0] ba, input logic last,
                        input int bound, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < bound && !ok; c++) begin
            @(negedge clk);
            if (sel) begin
                bus_b.in_valid = 1'b1; bus_b.in_opcode = op; bus_b.in_da = da;
                bus_b.in_aa = aa; bus_b.in_ba = ba; bus_b.in_last = last;
            end else begin
                bus_a.in_valid = 1'b1; bus_a.in_opcode = op; bus_a.in_da = da;
                bus_a.in_aa = aa; bus_a.in_ba = ba; bus_a.in_last = last;
            end
            #1;
            ok = sel ? bus_b.in_ready : bus_a.in_ready;
        end
        if (!ok) begin
            bus_a.in_valid = 1'b0;
            bus_b.in_valid = 1'b0;
        end
    endtask

    task automatic push_idx(input bit sel, input int i, input logic last, input int bound,
                            output bit ok);
        push(sel, 8'(16 + i), 3'(i), 3'(7 - i), 3'(i + 1), last, bound, ok);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int acc;
        int dc;
        logic [16:0] xsum;

        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        bus_a.in_valid = 0; bus_a.in_opcode = 0; bus_a.in_da = 0; bus_a.in_aa = 0;
        bus_a.in_ba = 0; bus_a.in_last = 0; bus_a.im_ready = 0;
        bus_b.in_valid = 0; bus_b.in_opcode = 0; bus_b.in_da = 0; bus_b.in_aa = 0;
        bus_b.in_ba = 0; bus_b.in_last = 0; bus_b.im_ready = 0;
        #2 rst = 1'b1;
        #1;
        check_val("rst_in_ready", bus_a.in_ready, 0);
        check_val("rst_im_we", bus_a.im_we, 0);
        check_val("rst_im_addr", bus_a.im_addr, 0);
        check_val("rst_im_wdata", bus_a.im_wdata, 0);
        check_val("rst_done", done_a, 0);
        check_val("rst_ovf", ovf_a, 0);
        check_val("rst_words", words_a, 0);
        check_val("rst_cksum", cksum_a, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_val("idle_in_ready", bus_a.in_ready, 0);

        // Single-word program.
        bus_a.im_ready = 1'b1;
        pulse_start(0);
        push(0, 8'h0D, 3'd1, 3'd2, 3'd0, 1'b1, 1, ok);
        check_val("push_after_start", ok, 1);
        step();
        check_val("single_we", bus_a.im_we, 1);
        check_val("single_addr", bus_a.im_addr, 0);
        check_val("single_wdata", bus_a.im_wdata, 17'h01A50);
        check_val("single_done_early", done_a, 0);
        step();
        check_val("single_done", done_a, 1);
        check_val("single_words", words_a, 1);
        check_val("single_we_after", bus_a.im_we, 0);
        check_val("single_ready_after", bus_a.in_ready, 0);
        check_val("single_cksum", cksum_a, CK_EN ? 17'h01A50 : 17'h0);
        step();
        check_val("single_done_pulse", done_a, 0);
        check_val("single_log_len", log_addr_a.size(), 1);
        check_val("single_done_cnt", done_cnt_a, 1);

        // Back-pressure: FIFO fills after 4, then drains in order.
        log_addr_a.delete(); log_data_a.delete();
        dc = done_cnt_a;
        bus_a.im_ready = 1'b0;
        pulse_start(0);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            push_idx(0, i, i == 5, 3, ok);
            if (!ok) break;
            acc++;
        end
        check_val("bp_accepted", acc, 4);
        check_val("bp_full_ready", bus_a.in_ready, 0);
        check_val("bp_stall_we", bus_a.im_we, 1);
        check_val("bp_stall_addr", bus_a.im_addr, 0);
        check_val("bp_stall_wdata", bus_a.im_wdata, 17'h02039);
        repeat (3) step();
        check_val("bp_hold_addr", bus_a.im_addr, 0);
        check_val("bp_hold_wdata", bus_a.im_wdata, 17'h02039);
        check_val("bp_hold_words", words_a, 0);
        bus_a.im_ready = 1'b1;
        for (int i = acc; i < 6; i++) begin
            push_idx(0, i, i == 5, 8, ok);
            check_val("bp_refill", ok, 1);
        end
        repeat (8) step();
        check_val("bp_log_len", log_addr_a.size(), 6);
        xsum = '0;
        for (int i = 0; i < 6; i++) begin
            xsum ^= exp_word(i);
            if (i < log_addr_a.size()) begin
                check_val("bp_addr", log_addr_a[i], i);
                check_val("bp_data", log_data_a[i], exp_word(i));
            end
        end
        check_val("bp_words", words_a, 6);
        check_val("bp_done_cnt", done_cnt_a - dc, 1);
        check_val("bp_cksum", cksum_a, CK_EN ? xsum : 17'h0);

        // Restart mid-load with three words buffered after one write.
        bus_a.im_ready = 1'b1;
        pulse_start(0);
        push_idx(0, 0, 1'b0, 2, ok);
        push_idx(0, 1, 1'b0, 2, ok);
        push_idx(0, 2, 1'b0, 2, ok);
        bus_a.im_ready = 1'b0;
        push_idx(0, 3, 1'b0, 2, ok);
        step();
        check_val("mid_words_before", words_a, 1);
        check_val("mid_addr_before", bus_a.im_addr, 1);
        check_val("mid_we_before", bus_a.im_we, 1);
        @(negedge clk);
        start_a = 1'b1;
        #1;
        check_val("mid_start_ready", bus_a.in_ready, 0);
        check_val("mid_start_we", bus_a.im_we, 0);
        @(posedge clk);
        #1 start_a = 1'b0;
        step();
        check_val("mid_flushed_we", bus_a.im_we, 0);
        check_val("mid_words", words_a, 0);
        check_val("mid_addr", bus_a.im_addr, 0);
        check_val("mid_ovf", ovf_a, 0);
        check_val("mid_cksum", cksum_a, 0);
        log_addr_a.delete(); log_data_a.delete();
        bus_a.im_ready = 1'b1;
        push_idx(0, 7, 1'b1, 2, ok);
        repeat (3) step();
        check_val("mid_log_len", log_addr_a.size(), 1);
        if (log_addr_a.size() > 0) begin
            check_val("mid_log_addr", log_addr_a[0], 0);
            check_val("mid_log_data", log_data_a[0], 17'h02FC0);
        end

        // Checksum of two known words.
        pulse_start(0);
        push(0, 8'h0D, 3'd1, 3'd2, 3'd0, 1'b0, 2, ok);
        push(0, 8'hFF, 3'd7, 3'd7, 3'd7, 1'b1, 2, ok);
        repeat (3) step();
        check_val("ck_words", words_a, 2);
        check_val("ck_value", cksum_a, CK_EN ? 17'h1E5AF : 17'h0);

        // Asynchronous reset while a write is stalled.
        bus_a.im_ready = 1'b1;
        pulse_start(0);
        push_idx(0, 0, 1'b0, 2, ok);
        push_idx(0, 1, 1'b0, 2, ok);
        step();
        bus_a.im_ready = 1'b0;
        check_val("ar_words_before", words_a, 1);
        check_val("ar_addr_before", bus_a.im_addr, 1);
        check_val("ar_wdata_before", bus_a.im_wdata, 17'h02272);
        check_val("ar_we_before", bus_a.im_we, 1);
        #1 rst = 1'b1;
        #1;
        check_val("ar_we", bus_a.im_we, 0);
        check_val("ar_addr", bus_a.im_addr, 0);
        check_val("ar_wdata", bus_a.im_wdata, 0);
        check_val("ar_words", words_a, 0);
        check_val("ar_cksum", cksum_a, 0);
        @(negedge clk);
        rst = 1'b0;
        log_addr_a.delete(); log_data_a.delete();
        bus_a.im_ready = 1'b1;
        push_idx(0, 2, 1'b1, 5, ok);
        check_val("ar_no_accept", ok, 0);
        repeat (2) step();
        check_val("ar_no_write", log_addr_a.size(), 0);
        check_val("ar_we_idle", bus_a.im_we, 0);

        // Address-space exhaustion on the 3-bit instance.
        bus_b.im_ready = 1'b1;
        pulse_start(1);
        for (int i = 0; i < 9; i++) begin
            push_idx(1, i, 1'b0, 2, ok);
        end
        repeat (4) step();
        check_val("ovf_log_len", log_addr_b.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_addr_b.size()) check_val("ovf_addr", log_addr_b[i], i);
        end
        if (log_data_b.size() > 7) check_val("ovf_last_data", log_data_b[7], exp_word(7));
        check_val("ovf_flag", ovf_b, 1);
        check_val("ovf_we", bus_b.im_we, 0);
        check_val("ovf_ready", bus_b.in_ready, 0);
        check_val("ovf_words", words_b, 8);
        check_val("ovf_done", done_b, 0);
        pulse_start(1);
        step();
        check_val("ovf_cleared", ovf_b, 0);
        check_val("ovf_restart_words", words_b, 0);
        check_val("ovf_restart_addr", bus_b.im_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder and program loader for the 17-bit datapath instruction word, the encoding-side counterpart to the instruction decoder. It accepts field tuples (opcode, DA, AA, BA) over a valid/ready handshake and packs each into a 17-bit word. Words are buffered in a small FIFO and written sequentially into instruction memory through a write port with back-pressure. It sits between the bench/host program source and instruction memory, and fills memory before the CPU is released.

## Interface
- ADDR_W, 8: instruction memory address width.
- FIFO_DEPTH, 4: packed-word buffer depth; power of 2, at least 2.
- BASE_ADDR, 0: first memory address written after `start`.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or restarts a load.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  encoder can accept a tuple this cycle.
- in_opcode  in  8  opcode field.
- in_da / in_aa / in_ba  in  3 each  destination, A and B register address fields.
- in_last  in  1  marks the final tuple of the program.
- im_we  out  1  memory write request.
- im_ready  in  1  memory accepts the write this cycle.
- im_addr  out  ADDR_W  write address.
- im_wdata  out  17  packed instruction.
- done  out  1  one-cycle pulse after the last word is written.
- ovf  out  1  sticky; address space was exhausted before `last`.
- words  out  ADDR_W+1  count of words written since `start`.
- cksum  out  17  running checksum (see Configuration).

## Operation
- Packing: word = {opcode[7:0], DA[2:0], AA[2:0], BA[2:0]}. Bits [16:9] hold the opcode; [8:6] DA; [5:3] AA; [2:0] BA. The `last` flag is stored alongside the word in the FIFO.
- States:
  - IDLE (after reset): in_ready=0, im_we=0. start → LOAD.
  - LOAD: in_ready = !full && !start. A push occurs when in_valid && in_ready. im_we = !empty && !start. A write occurs when im_we && im_ready: FIFO pops, im_addr increments, words increments.
    - Written word flagged last → DONE, done=1 for one cycle.
    - Written word at address 2^ADDR_W−1 without last → ERR, ovf=1. Remaining FIFO contents are discarded.
  - DONE / ERR: in_ready=0, im_we=0. start → LOAD.
- start (from any state): flushes the FIFO, sets im_addr=BASE_ADDR, words=0 and cksum=0, and clears ovf. No push and no write occur in the start cycle.
- Full FIFO: in_ready=0 even if a pop happens in the same cycle. No simultaneous push-on-full.
- Empty FIFO with a simultaneous push: the word is not written in the push cycle. It is presented the following cycle.
- im_addr does not wrap. Reaching the top of the address space ends the load in ERR.

## Timing
- Reset values: in_ready=0, im_we=0, im_addr=BASE_ADDR, im_wdata=0, done=0, ovf=0, words=0, cksum=0, state IDLE.
- First push is possible in the cycle after start. A word pushed in cycle N is presented on im_wdata/im_we in cycle N+1 at the earliest.
- Sustained throughput is 1 word per cycle while im_ready=1 and in_valid=1.
- im_addr, im_wdata and im_we are held stable while im_we=1 and im_ready=0.
- done is asserted in the cycle after the write of the last word.
- Reset asserted mid-load aborts immediately. No further im_we is issued until a new start.

## Configuration
- INST_ENCODER_CKSUM_EN defined: cksum holds the XOR of every 17-bit word written since start. It updates in the cycle after each write.
- Not defined: cksum is tied to 0 and no checksum logic is instantiated.

## Test plan
- Reset then start; push opcode 8'h0D, DA=1, AA=2, BA=0, last=1 with im_ready=1 → single write im_addr=0, im_wdata=17'h01A50; done pulses once; words=1.
- Push 6 tuples back-to-back with im_ready=0 → in_ready drops after 4 accepted. Raise im_ready → addresses 0..5 are written in order with no gaps or duplicates.
- ADDR_W=3; push 9 tuples with no last → 8 writes (addresses 0..7), then ERR, ovf=1, im_we=0, 9th word never written.
- Mid-load start with 3 words buffered → FIFO flushed, next write goes to BASE_ADDR, words=0, ovf=0.
- Assert rst while im_we=1 and im_ready=0 → all outputs return to reset values asynchronously; no write after release until start.
- With INST_ENCODER_CKSUM_EN, write 17'h01A50 then 17'h1FFFF → cksum=17'h1E5AF. Without the macro, cksum stays 0.
